lcd_init_seq: RTL and testbench

//  Upstream write sequencer for the 16-bit 8080-style LCD bus engine. After reset it walks an

---
 rtl/lcd_pkg.sv | 36 +++
 rtl/lcd_init_rom.sv | 65 ++++++
 rtl/lcd_init_seq.sv | 142 ++++++++++++++
 tb/tb_lcd_init_seq.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared types for the LCD init sequencer: table entry layout and sequencer FSM states.
package lcd_pkg;

  typedef enum logic [1:0] {
    OP_CMD   = 2'b00,
    OP_DATA  = 2'b01,
    OP_DELAY = 2'b10,
    OP_END   = 2'b11
  } init_op_t;

  typedef struct packed {
    init_op_t    op;
    logic [15:0] val;
  } init_entry_t;

  typedef enum logic [3:0] {
    StPwrWait,
    StFetch,
    StDecode,
    StIssue,
    StWaitAck,
    StWaitIdle,
    StDelay,
    StNext,
    StDone,
    StError
  } init_state_t;

  function automatic init_entry_t mk_entry(input init_op_t op, input logic [15:0] val);
    init_entry_t e;
    e.op  = op;
    e.val = val;
    return e;
  endfunction

endpackage

// File: rtl/lcd_init_rom.sv
// Panel init table with a registered read port (1-cycle latency).
// TABLE_SEL 0 is the production panel table; the others are short bring-up tables.
module lcd_init_rom import lcd_pkg::*; #(
  parameter int unsigned ROM_DEPTH = 128,
  parameter int unsigned TABLE_SEL = 0,
  localparam int unsigned ADDR_W = $clog2(ROM_DEPTH)
) (
  input  logic              pclk,
  input  logic [ADDR_W-1:0] addr,
  output init_entry_t       entry
);

  int unsigned a;
  init_entry_t lookup;

  always_comb begin
    a      = 32'(addr);
    lookup = mk_entry(OP_END, 16'h0000);
    case (TABLE_SEL)
      1: begin
        case (a)
          0:       lookup = mk_entry(OP_CMD,   16'h0011);
          1:       lookup = mk_entry(OP_DELAY, 16'd2);
          2:       lookup = mk_entry(OP_CMD,   16'h0029);
          default: lookup = mk_entry(OP_END,   16'h0000);
        endcase
      end
      2: begin
        case (a)
          0:       lookup = mk_entry(OP_CMD,  16'h003A);
          1:       lookup = mk_entry(OP_DATA, 16'h0055);
          default: lookup = mk_entry(OP_END,  16'h0000);
        endcase
      end
      3: begin
        // Deliberately has no END entry.
        case (a)
          0:       lookup = mk_entry(OP_CMD,   16'h0001);
          1:       lookup = mk_entry(OP_DELAY, 16'd1);
          2:       lookup = mk_entry(OP_DATA,  16'h0002);
          default: lookup = mk_entry(OP_DATA,  16'h0003);
        endcase
      end
      default: begin
        case (a)
          0:       lookup = mk_entry(OP_CMD,   16'h0001);  // software reset
          1:       lookup = mk_entry(OP_DELAY, 16'd120);
          2:       lookup = mk_entry(OP_CMD,   16'h0011);  // sleep out
          3:       lookup = mk_entry(OP_DELAY, 16'd120);
          4:       lookup = mk_entry(OP_CMD,   16'h003A);  // pixel format
          5:       lookup = mk_entry(OP_DATA,  16'h0055);
          6:       lookup = mk_entry(OP_CMD,   16'h0036);  // memory access control
          7:       lookup = mk_entry(OP_DATA,  16'h0048);
          8:       lookup = mk_entry(OP_CMD,   16'h0029);  // display on
          default: lookup = mk_entry(OP_END,   16'h0000);
        endcase
      end
    endcase
  end

  always_ff @(posedge pclk) begin
    entry <= lookup;
  end

endmodule

// File: rtl/lcd_init_seq.sv
// Walks the panel init table after power-up and issues one engine write per CMD/DATA entry,
// honouring table delays; ends in DONE (init_done) or ERROR (init_err).
module lcd_init_seq import lcd_pkg::*; #(
  parameter int unsigned PWR_WAIT    = 2_500_000,
  parameter int unsigned DELAY_UNIT  = 50_000,
  parameter int unsigned ACK_TIMEOUT = 64,
  parameter int unsigned ROM_DEPTH   = 128,
  parameter int unsigned TABLE_SEL   = 0,
  localparam int unsigned ADDR_W = $clog2(ROM_DEPTH)
) (
  input  logic              pclk,
  input  logic              rst,
  input  logic              busy_i,
  input  logic              init_write_ok_i,
  output logic [15:0]       data_o,
  output logic              lcd_rs_o,
  output logic              we_o,
  output logic              wr_o,
  output logic              id_fm_o,
  output logic              read_color_o,
  output logic              init_done,
  output logic              init_err,
  output logic [ADDR_W-1:0] entry_idx
);

  init_state_t       state_q, state_d;
  logic [31:0]       cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       data_q, data_d;
  logic              rs_q, rs_d;
  init_entry_t       entry;

  lcd_init_rom #(
    .ROM_DEPTH(ROM_DEPTH),
    .TABLE_SEL(TABLE_SEL)
  ) u_rom (
    .pclk (pclk),
    .addr (addr_q),
    .entry(entry)
  );

  always_ff @(posedge pclk) begin
    if (rst) begin
      state_q <= StPwrWait;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      rs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      rs_q    <= rs_d;
    end
  end

  // cnt_q is shared: power-on wait, ack timeout and table delay never overlap.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    rs_d    = rs_q;
    we_o    = 1'b0;
    unique case (state_q)
      StPwrWait: begin
        if (cnt_q >= PWR_WAIT - 1) begin
          state_d = StFetch;
          addr_d  = '0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      StFetch: state_d = StDecode;
      StDecode: begin
        unique case (entry.op)
          OP_CMD, OP_DATA: begin
            data_d  = entry.val;
            rs_d    = entry.op[0];
            state_d = StIssue;
          end
          OP_DELAY: begin
            if (entry.val == 16'd0) begin
              state_d = StNext;
            end else begin
              cnt_d   = 32'(entry.val) * DELAY_UNIT;
              state_d = StDelay;
            end
          end
          OP_END: state_d = StDone;
        endcase
      end
      StIssue: begin
        if (!busy_i) begin
          we_o    = 1'b1;
          cnt_d   = 32'd1;
          state_d = StWaitAck;
        end
      end
      StWaitAck: begin
        // Timeout lands ERROR exactly ACK_TIMEOUT cycles after the we_o pulse.
        if (init_write_ok_i) begin
          state_d = StWaitIdle;
        end else if (cnt_q >= ACK_TIMEOUT - 1) begin
          state_d = StError;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      StWaitIdle: begin
        if (!busy_i) state_d = StNext;
      end
      StDelay: begin
        if (cnt_q <= 32'd1) state_d = StNext;
        else                cnt_d   = cnt_q - 32'd1;
      end
      StNext: begin
        if (addr_q == ADDR_W'(ROM_DEPTH - 1)) begin
          state_d = StError;
        end else begin
          addr_d  = addr_q + ADDR_W'(1);
          state_d = StFetch;
        end
      end
      StDone:  state_d = StDone;
      StError: state_d = StError;
      default: state_d = StError;
    endcase
  end

  assign data_o       = data_q;
  assign lcd_rs_o     = rs_q;
  assign wr_o         = 1'b1;
  assign id_fm_o      = 1'b0;
  assign read_color_o = 1'b0;
  assign init_done    = (state_q == StDone);
  assign init_err     = (state_q == StError);
  assign entry_idx    = addr_q;

endmodule

// File: tb/tb_lcd_init_seq.sv
// Directed bench for lcd_init_seq: three instances with different init tables, each driven by
// a small engine stub (busy at +1, ok at +3, busy low at +4 after we_o).
module tb_lcd_init_seq;

  logic pclk = 1'b0;
  always #5 pclk = ~pclk;

  logic rst [3];
  logic mute [3];
  int   hold_until [3];
  int   n_cmp = 0;
  int   n_bad = 0;

  for (genvar g = 0; g < 3; g++) begin : d
    localparam int unsigned Depth = (g == 2) ? 4 : 128;

    logic busy, ok, we, wr, idfm, rdc, rs, done, err;
    logic [15:0] data;
    logic [$clog2(Depth)-1:0] eidx;
    int idx, cyc, nwe, err_cyc, dbl;
    logic [1:0] s;
    logic pend;
    int we_cyc [4];
    logic [15:0] we_dat [4];
    logic we_rs [4];
    logic [15:0] ok_dat;
    logic ok_rs;

    lcd_init_seq #(
      .PWR_WAIT   (10),
      .DELAY_UNIT (5),
      .ACK_TIMEOUT(16),
      .ROM_DEPTH  (Depth),
      .TABLE_SEL  (g + 1)
    ) u_dut (
      .pclk           (pclk),
      .rst            (rst[g]),
      .busy_i         (busy),
      .init_write_ok_i(ok),
      .data_o         (data),
      .lcd_rs_o       (rs),
      .we_o           (we),
      .wr_o           (wr),
      .id_fm_o        (idfm),
      .read_color_o   (rdc),
      .init_done      (done),
      .init_err       (err),
      .entry_idx      (eidx)
    );

    assign idx  = 32'(eidx);
    assign busy = (s != 2'd0) || (cyc < hold_until[g]);
    assign ok   = (s == 2'd3) && !mute[g];

    always @(posedge pclk) begin
      cyc <= rst[g] ? 0 : cyc + 1;
      if (rst[g])         s <= 2'd0;
      else if (we)        s <= 2'd1;
      else if (s == 2'd3) s <= 2'd0;
      else if (s != 2'd0) s <= s + 2'd1;
    end

    always @(negedge pclk) begin
      if (rst[g]) begin
        nwe <= 0; pend <= 1'b0; err_cyc <= -1; dbl <= 0;
      end else begin
        if (we) begin
          if (pend) dbl <= dbl + 1;
          if (nwe < 4) begin
            we_cyc[nwe[1:0]] <= cyc;
            we_dat[nwe[1:0]] <= data;
            we_rs[nwe[1:0]]  <= rs;
          end
          nwe  <= nwe + 1;
          pend <= 1'b1;
        end
        if (ok) begin
          pend <= 1'b0; ok_dat <= data; ok_rs <= rs;
        end
        if (err && err_cyc < 0) err_cyc <= cyc;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge pclk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      rst[i] = 1'b1; mute[i] = 1'b0; hold_until[i] = 0;
    end
    tick(2);
    check("rst_we",   32'(d[0].we),   32'd0);
    check("rst_wr",   32'(d[0].wr),   32'd1);
    check("rst_data", 32'(d[0].data), 32'd0);
    check("rst_rs",   32'(d[0].rs),   32'd0);
    check("rst_done", 32'(d[0].done), 32'd0);
    check("rst_err",  32'(d[0].err),  32'd0);
    check("rst_idfm", 32'(d[0].idfm), 32'd0);
    check("rst_rdc",  32'(d[0].rdc),  32'd0);
    check("rst_idx",  32'(d[2].idx),  32'd0);
    for (int i = 0; i < 3; i++) rst[i] = 1'b0;
    tick(60);

    // Table {CMD 0x11, DELAY 2, CMD 0x29, END}
    check("a_nwe",   32'(d[0].nwe),       32'd2);
    check("a_cyc0",  32'(d[0].we_cyc[0]), 32'd12);
    check("a_dat0",  32'(d[0].we_dat[0]), 32'h0011);
    check("a_rs0",   32'(d[0].we_rs[0]),  32'd0);
    check("a_cyc1",  32'(d[0].we_cyc[1]), 32'd33);
    check("a_dat1",  32'(d[0].we_dat[1]), 32'h0029);
    check("a_done",  32'(d[0].done),      32'd1);
    check("a_err",   32'(d[0].err),       32'd0);
    check("a_dbl",   32'(d[0].dbl),       32'd0);

    // Table {CMD 0x3A, DATA 0x55, END}
    check("b_nwe",   32'(d[1].nwe),       32'd2);
    check("b_cyc0",  32'(d[1].we_cyc[0]), 32'd12);
    check("b_dat0",  32'(d[1].we_dat[0]), 32'h003A);
    check("b_rs0",   32'(d[1].we_rs[0]),  32'd0);
    check("b_cyc1",  32'(d[1].we_cyc[1]), 32'd20);
    check("b_dat1",  32'(d[1].we_dat[1]), 32'h0055);
    check("b_rs1",   32'(d[1].we_rs[1]),  32'd1);
    check("b_okdat", 32'(d[1].ok_dat),    32'h0055);
    check("b_okrs",  32'(d[1].ok_rs),     32'd1);
    check("b_done",  32'(d[1].done),      32'd1);

    // ROM_DEPTH 4 without END
    check("c_nwe",   32'(d[2].nwe),       32'd3);
    check("c_errcy", 32'(d[2].err_cyc),   32'd42);
    check("c_err",   32'(d[2].err),       32'd1);
    check("c_done",  32'(d[2].done),      32'd0);
    check("c_idx",   32'(d[2].idx),       32'd3);
    check("c_we",    32'(d[2].we),        32'd0);

    // Engine busy for the first 32 cycles: ISSUE stalls, then a single pulse
    rst[0] = 1'b1; hold_until[0] = 32;
    tick(2);
    rst[0] = 1'b0;
    tick(80);
    check("h_cyc0",  32'(d[0].we_cyc[0]), 32'd32);
    check("h_cyc1",  32'(d[0].we_cyc[1]), 32'd53);
    check("h_nwe",   32'(d[0].nwe),       32'd2);
    check("h_err",   32'(d[0].err),       32'd0);
    check("h_done",  32'(d[0].done),      32'd1);
    check("h_dbl",   32'(d[0].dbl),       32'd0);

    // Engine never acks: error ACK_TIMEOUT (16) cycles after the pulse
    rst[0] = 1'b1; hold_until[0] = 0; mute[0] = 1'b1;
    tick(2);
    rst[0] = 1'b0;
    tick(60);
    check("t_nwe",   32'(d[0].nwe),       32'd1);
    check("t_errcy", 32'(d[0].err_cyc),   32'd28);
    check("t_err",   32'(d[0].err),       32'd1);
    check("t_done",  32'(d[0].done),      32'd0);
    check("t_we",    32'(d[0].we),        32'd0);

    // Reset while waiting for the second write's ack
    rst[0] = 1'b1; mute[0] = 1'b0;
    tick(2);
    rst[0] = 1'b0;
    tick(34);
    check("r_nwe",   32'(d[0].nwe),       32'd2);
    check("r_data",  32'(d[0].data),      32'h0029);
    check("r_idx",   32'(d[0].idx),       32'd2);
    rst[0] = 1'b1;
    tick(1);
    check("r_rdata", 32'(d[0].data),      32'd0);
    check("r_ridx",  32'(d[0].idx),       32'd0);
    check("r_rwe",   32'(d[0].we),        32'd0);
    check("r_rwr",   32'(d[0].wr),        32'd1);
    check("r_rdone", 32'(d[0].done),      32'd0);
    check("r_rerr",  32'(d[0].err),       32'd0);
    tick(1);
    rst[0] = 1'b0;
    tick(60);
    check("r_cyc0",  32'(d[0].we_cyc[0]), 32'd12);
    check("r_dat0",  32'(d[0].we_dat[0]), 32'h0011);
    check("r_nwe2",  32'(d[0].nwe),       32'd2);
    check("r_done",  32'(d[0].done),      32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
